uart_peripheral: RTL and testbench

UART_PERIPHERAL -- requirements
Module: uart_peripheral

---
 rtl/uart_peripheral_pkg.sv | 29 ++
 rtl/uart_fifo.sv | 50 +++++
 rtl/uart_peripheral.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_peripheral.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_peripheral_pkg.sv
// Shared definitions for the UART peripheral: bus modes, register map, STATUS layout, FSM states.
package uart_peripheral_pkg;

  localparam logic [1:0] BusRead  = 2'b01;
  localparam logic [1:0] BusWrite = 2'b10;

  localparam logic [3:0]  RegData   = 4'h0;
  localparam logic [3:0]  RegStatus = 4'h4;
  localparam logic [3:0]  RegCtrl   = 4'h8;
  localparam logic [31:0] RegSpan   = 32'd12;

  localparam int unsigned StTxFull  = 0;
  localparam int unsigned StTxEmpty = 1;
  localparam int unsigned StRxValid = 2;
  localparam int unsigned StOverrun = 3;
  localparam int unsigned StTxBusy  = 4;

  localparam int unsigned CtrlRxIrqEn = 16;
  localparam int unsigned CtrlTxIrqEn = 17;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // A divisor below 2 would leave no room for the half-bit start check.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO used for both UART directions; a pop frees a slot for a push in the same cycle.
module uart_fifo #(
  parameter int unsigned depth = 4,
  localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1,
  localparam int unsigned CntW = $clog2(depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [7:0]      wdata,
  input  logic            pop,
  output logic [7:0]      rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [7:0]      mem_q [depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(depth));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART with TX FIFO, RX storage, programmable divisor and level interrupt.
// Build option UART_RX_FIFO_EN: 4-deep RX FIFO; otherwise a single RX holding register.
module uart_peripheral
  import uart_peripheral_pkg::*;
#(
  parameter logic [31:0] base_address = 32'h40E0,
  parameter logic [15:0] default_div  = 16'd104
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] data_bus_read,
  input  logic [31:0] data_bus_write,
  input  logic        data_bus_select,
  input  logic [31:0] data_bus_addr,
  input  logic [1:0]  data_bus_mode,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        uart_irq
);

`ifdef UART_RX_FIFO_EN
  localparam int unsigned RxDepth = 4;
`else
  localparam int unsigned RxDepth = 1;
`endif
  localparam int unsigned RxCntW = $clog2(RxDepth + 1);

  logic [31:0] offset, status;
  logic [3:0]  reg_sel;
  logic        rd_acc, wr_acc, status_rd;
  logic [15:0] div_q, div_eff;
  logic        rx_irq_en_q, tx_irq_en_q, overrun_q, unused_wdata;

  // Addresses below the base wrap to large offsets and fall out of range.
  assign offset    = data_bus_addr - base_address;
  assign reg_sel   = {offset[3:2], 2'b00};
  assign rd_acc    = data_bus_select && (offset < RegSpan) && (data_bus_mode == BusRead);
  assign wr_acc    = data_bus_select && (offset < RegSpan) && (data_bus_mode == BusWrite);
  assign status_rd = rd_acc && (reg_sel == RegStatus);
  assign div_eff   = eff_div(div_q);
  assign unused_wdata = ^data_bus_write[31:18];

  logic       tx_push, tx_pop, tx_full, tx_empty, tx_busy;
  logic [7:0] tx_rdata;
  logic [2:0] unused_tx_count;
  logic       rx_push, rx_pop, rx_full, rx_empty, rx_valid;
  logic [7:0] rx_rdata;
  logic [RxCntW-1:0] unused_rx_count;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;

  assign tx_push  = wr_acc && (reg_sel == RegData);
  assign rx_valid = ~rx_empty;
  assign rx_pop   = rd_acc && (reg_sel == RegData) && rx_valid;

  uart_fifo #(.depth(4)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .wdata(data_bus_write[7:0]), .pop(tx_pop),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(unused_tx_count)
  );

  uart_fifo #(.depth(RxDepth)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .wdata(rx_shift_q), .pop(rx_pop),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(unused_rx_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= default_div;
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (wr_acc && (reg_sel == RegCtrl)) begin
        div_q       <= data_bus_write[15:0];
        rx_irq_en_q <= data_bus_write[CtrlRxIrqEn];
        tx_irq_en_q <= data_bus_write[CtrlTxIrqEn];
      end
      // A new overrun wins over a concurrent STATUS read so it is never lost.
      if (rx_push && rx_full && !rx_pop) overrun_q <= 1'b1;
      else if (status_rd)               overrun_q <= 1'b0;
    end
  end

  always_comb begin
    status            = '0;
    status[StTxFull]  = tx_full;
    status[StTxEmpty] = tx_empty;
    status[StRxValid] = rx_valid;
    status[StOverrun] = overrun_q;
    status[StTxBusy]  = tx_busy;
    data_bus_read     = '0;
    if (reset && rd_acc) begin
      case (reg_sel)
        RegData:   data_bus_read = rx_valid ? {24'h0, rx_rdata} : '0;
        RegStatus: data_bus_read = status;
        RegCtrl:   data_bus_read = {14'h0, tx_irq_en_q, rx_irq_en_q, div_q};
        default:   data_bus_read = '0;
      endcase
    end
  end

  assign uart_irq = (rx_irq_en_q & rx_valid) | (tx_irq_en_q & tx_empty & ~tx_busy);

  // Transmitter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    if (tx_state_q != TxIdle) tx_cnt_d = tx_cnt_q - 16'd1;
    unique case (tx_state_q)
      TxIdle: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_rdata;
          tx_cnt_d   = div_eff - 16'd1;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = div_eff - 16'd1;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = div_eff - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TxStop;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end
      TxStop: begin
        if (tx_cnt_q == '0) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_rdata;
            tx_cnt_d   = div_eff - 16'd1;
            tx_state_d = TxStart;
          end else begin
            tx_state_d = TxIdle;
          end
        end
      end
    endcase
  end

  assign tx_busy = (tx_state_q != TxIdle);
  assign uart_tx = (tx_state_q == TxStart) ? 1'b0 :
                   (tx_state_q == TxData)  ? tx_shift_q[0] : 1'b1;

  // Receiver
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    if (rx_state_q != RxIdle) rx_cnt_d = rx_cnt_q - 16'd1;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = (div_eff >> 1) - 16'd1;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = div_eff - 16'd1;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = div_eff - 16'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == '0) begin
          rx_push    = rx_s2_q;
          rx_state_d = RxIdle;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_peripheral.sv
// Self-checking bench for uart_peripheral: register vectors, serial frame checks, random TX/RX.
module tb_uart_peripheral;

  localparam logic [31:0] Base  = 32'h40E0;
  localparam logic [31:0] AData = Base;
  localparam logic [31:0] AStat = Base + 32'd4;
  localparam logic [31:0] ACtrl = Base + 32'd8;
`ifdef UART_RX_FIFO_EN
  localparam int RxCap = 4;
`else
  localparam int RxCap = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rdata, wdata, addr;
  logic        sel;
  logic [1:0]  mode;
  logic        uart_rx, uart_tx, uart_irq;

  uart_peripheral #(.base_address(Base), .default_div(16'd104)) dut (
    .clk(clk), .reset(reset), .data_bus_read(rdata), .data_bus_write(wdata),
    .data_bus_select(sel), .data_bus_addr(addr), .data_bus_mode(mode),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_irq(uart_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit exp_bits[$];
  logic [7:0] rxq[$];
  bit ovr_m = 1'b0;

  typedef struct {
    logic        sel;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic bus_idle();
    sel = 1'b0; mode = 2'b00; addr = '0; wdata = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; mode = 2'b10; addr = a; wdata = d;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    sel = 1'b1; mode = 2'b01; addr = a;
    #1 d = rdata;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  function automatic int eff_of(input int raw);
    return (raw < 2) ? 2 : raw;
  endfunction

  task automatic add_frame(input logic [7:0] b);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(1'b1);
  endtask

  // Waits for a start bit, then demands every queued bit hold for exactly eff cycles, gap-free.
  task automatic expect_tx(input int eff, input string name);
    int t;
    int n;
    bit b;
    logic seen;
    t = 0;
    n = 0;
    while (uart_tx !== 1'b0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (uart_tx !== 1'b0) begin
      check({name, " start timeout"}, uart_tx, 32'h0);
      exp_bits.delete();
      return;
    end
    while (exp_bits.size() > 0) begin
      b = exp_bits.pop_front();
      seen = b;
      for (int c = 0; c < eff; c++) begin
        if (uart_tx !== b) seen = uart_tx;
        @(posedge clk); #1;
      end
      check($sformatf("%s bit%0d", name, n), seen, b);
      n++;
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input int eff, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (eff) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference receive side: bounded byte queue plus a sticky overrun flag.
  task automatic m_deliver(input logic [7:0] b);
    if (rxq.size() < RxCap) rxq.push_back(b);
    else ovr_m = 1'b1;
  endtask

  task automatic m_status(input string name);
    logic [31:0] e;
    e = 32'h2;
    if (rxq.size() > 0) e = e | 32'h4;
    if (ovr_m) e = e | 32'h8;
    read_check(name, AStat, e);
    ovr_m = 1'b0;
  endtask

  task automatic m_data(input string name);
    logic [31:0] e;
    e = '0;
    if (rxq.size() > 0) e = {24'h0, rxq.pop_front()};
    read_check(name, AData, e);
  endtask

  int raw, eff, n, t;
  logic [7:0] bs[4];
  logic [31:0] got;
  logic seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    uart_rx = 1'b1;
    bus_idle();
    sel = 1'b1; mode = 2'b01; addr = AStat;
    #1;
    check("reset rd", rdata, 32'h0);
    check("reset tx", uart_tx, 32'h1);
    check("reset irq", uart_irq, 32'h0);
    bus_idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{1'b1, 2'b01, AStat,        32'h0,     32'h2,     1'b0});
    vecs.push_back('{1'b1, 2'b01, ACtrl,        32'h0,     32'h68,    1'b0});
    vecs.push_back('{1'b1, 2'b01, AData,        32'h0,     32'h0,     1'b0});
    vecs.push_back('{1'b1, 2'b01, Base + 32'd12, 32'h0,    32'h0,     1'b0});
    vecs.push_back('{1'b0, 2'b01, AStat,        32'h0,     32'h0,     1'b0});
    vecs.push_back('{1'b1, 2'b11, AStat,        32'h0,     32'h0,     1'b0});
    vecs.push_back('{1'b1, 2'b10, ACtrl,        32'h20004, 32'h0,     1'b1});
    vecs.push_back('{1'b1, 2'b01, ACtrl,        32'h0,     32'h20004, 1'b1});
    vecs.push_back('{1'b1, 2'b10, Base + 32'd16, 32'hFFFF, 32'h0,     1'b1});
    vecs.push_back('{1'b0, 2'b10, ACtrl,        32'h0,     32'h0,     1'b1});
    vecs.push_back('{1'b1, 2'b00, ACtrl,        32'h0,     32'h0,     1'b1});
    vecs.push_back('{1'b1, 2'b01, ACtrl,        32'h0,     32'h20004, 1'b1});
    vecs.push_back('{1'b1, 2'b01, Base - 32'd4, 32'h0,     32'h0,     1'b1});
    vecs.push_back('{1'b1, 2'b10, ACtrl,        32'h4,     32'h0,     1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      sel = vecs[i].sel; mode = vecs[i].mode; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1 check($sformatf("vec%0d rd", i), rdata, vecs[i].exp_rd);
      @(posedge clk); #1;
      bus_idle();
      check($sformatf("vec%0d irq", i), uart_irq, vecs[i].exp_irq);
    end

    // Single frame at div 4
    bus_write(AData, 32'hA5);
    add_frame(8'hA5);
    expect_tx(4, "a5");
    read_check("a5 status", AStat, 32'h2);

    // F0 leads so that 01..04 are all queued while it is on the wire; 05 meets a full FIFO.
    fork
      begin
        add_frame(8'hF0);
        for (int b = 1; b <= 4; b++) add_frame(8'(b));
        expect_tx(4, "burst");
      end
      begin
        bus_write(AData, 32'hF0);
        for (int b = 1; b <= 4; b++) bus_write(AData, 32'(b));
        read_check("tx_full", AStat, 32'h11);
        bus_write(AData, 32'h05);
      end
    join
    seen = 1'b1;
    repeat (12) begin
      if (uart_tx !== 1'b1) seen = uart_tx;
      @(posedge clk); #1;
    end
    check("05 dropped", seen, 32'h1);
    read_check("burst status", AStat, 32'h2);

    // Random transmit bursts, including divisors below 2
    for (int it = 0; it < 4; it++) begin
      raw = $urandom_range(0, 6);
      eff = eff_of(raw);
      n = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) bs[k] = 8'($urandom);
      bus_write(ACtrl, 32'(raw));
      fork
        begin
          for (int k = 0; k < n; k++) add_frame(bs[k]);
          expect_tx(eff, $sformatf("rtx%0d", it));
        end
        begin
          for (int k = 0; k < n; k++) bus_write(AData, {24'h0, bs[k]});
        end
      join
    end

    // Receive at div 8
    bus_write(ACtrl, 32'h8);
    drive_rx(8'h3C, 8, 1'b1);
    m_deliver(8'h3C);
    m_status("rx 3c status");
    m_data("rx 3c data");
    m_status("rx 3c empty");

    uart_rx = 1'b0;
    @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    m_status("glitch");

    drive_rx(8'h55, 8, 1'b0);
    m_status("bad stop");

    drive_rx(8'h11, 8, 1'b1);
    m_deliver(8'h11);
    drive_rx(8'h22, 8, 1'b1);
    m_deliver(8'h22);
    m_status("ovr set");
    m_status("ovr clr");
    for (int k = 0; k <= RxCap; k++) m_data($sformatf("drain%0d", k));

    bus_write(ACtrl, 32'h10008);
    check("irq idle", uart_irq, 32'h0);
    drive_rx(8'h9A, 8, 1'b1);
    m_deliver(8'h9A);
    check("rx irq", uart_irq, 32'h1);
    m_data("irq data");
    check("irq clr", uart_irq, 32'h0);

    // Random receive with occasional reads, so overrun can arise
    for (int it = 0; it < 10; it++) begin
      raw = $urandom_range(0, 8);
      eff = eff_of(raw);
      bus_write(ACtrl, 32'(raw));
      bs[0] = 8'($urandom);
      drive_rx(bs[0], eff, 1'b1);
      m_deliver(bs[0]);
      if ($urandom_range(0, 1) == 1) begin
        m_status($sformatf("rrx%0d st", it));
        m_data($sformatf("rrx%0d dt", it));
      end
    end
    m_status("rrx final");
    for (int k = 0; k <= RxCap; k++) m_data($sformatf("rrx drain%0d", k));
    m_status("rrx empty");

    // Reset during a data bit of a 00 frame
    bus_write(ACtrl, 32'h8);
    bus_write(AData, 32'h00);
    t = 0;
    while (uart_tx !== 1'b0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (12) @(posedge clk);
    #3;
    check("pre-reset tx", uart_tx, 32'h0);
    reset = 1'b0;
    #1;
    check("async tx", uart_tx, 32'h1);
    check("async irq", uart_irq, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    read_check("post-reset status", AStat, 32'h2);
    read_check("post-reset ctrl", ACtrl, 32'h68);
    seen = 1'b1;
    repeat (20) begin
      if (uart_tx !== 1'b1) seen = uart_tx;
      @(posedge clk); #1;
    end
    check("post-reset idle", seen, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
